// File: rtl/mult_seq_ctrl_if.sv
// Operand/product handshake bundle for the sequential shift-and-add multiplier.
interface mult_seq_ctrl_if #(parameter int n = 5) ();
    logic                   in_valid;
    logic                   in_ready;
    logic [n-1:0]           in_multiplicand;
    logic [n-1:0]           in_multiplier;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*n-1:0]         out_product;
    logic [$clog2(n):0]     out_cycles;
    logic                   busy;

    modport slave (
        input  in_valid, in_multiplicand, in_multiplier, out_ready,
        output in_ready, out_valid, out_product, out_cycles, busy
    );

    modport master (
        output in_valid, in_multiplicand, in_multiplier, out_ready,
        input  in_ready, out_valid, out_product, out_cycles, busy
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock, IDLE/RUN/DONE.
// Define MULT_SEQ_SKIP_ZERO_EN to exit RUN early once the remaining multiplier bits are zero.
module mult_seq_ctrl #(
    parameter int n = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mult_seq_ctrl_if.slave        mul_if
);
    localparam int IW = (n > 1) ? $clog2(n) : 1;
    localparam int CW = $clog2(n) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [2*n-1:0]  mcand_q, acc_q;
    logic [n-1:0]    mplier_q;
    logic [IW-1:0]   idx_q;
    logic [CW-1:0]   cycles_q;

    logic            accept;
    logic            last;
    logic            skip;
    logic [2*n-1:0]  pp;

    assign accept = (state_q == IDLE) && mul_if.in_valid;
    assign pp     = mplier_q[idx_q] ? (mcand_q << idx_q) : '0;

`ifdef MULT_SEQ_SKIP_ZERO_EN
    // At idx = n-1 the shift amount may wrap, but last is already forced there.
    assign skip = ((mplier_q >> (idx_q + IW'(1))) == '0);
`else
    assign skip = 1'b0;
`endif

    assign last = (idx_q == IW'(n - 1)) || skip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mul_if.in_valid) state_d = RUN;
            RUN:     if (last)            state_d = DONE;
            DONE:    if (mul_if.out_ready) state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        mul_if.in_ready    = (state_q == IDLE);
        mul_if.out_valid   = (state_q == DONE);
        mul_if.busy        = (state_q == RUN) || (state_q == DONE);
        mul_if.out_product = acc_q;
        mul_if.out_cycles  = cycles_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            cycles_q <= '0;
        end else if (accept) begin
            mcand_q  <= (2*n)'(mul_if.in_multiplicand);
            mplier_q <= mul_if.in_multiplier;
            acc_q    <= '0;
            idx_q    <= '0;
            cycles_q <= '0;
        end else if (state_q == RUN) begin
            acc_q    <= acc_q + pp;
            idx_q    <= idx_q + IW'(1);
            cycles_q <= cycles_q + CW'(1);
        end
    end
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Randomized self-checking bench for mult_seq_ctrl against an arithmetic reference model.
module tb_mult_seq_ctrl;
    localparam int N = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mult_seq_ctrl_if #(.n(N)) bus ();

    mult_seq_ctrl #(.n(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mul_if (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected number of RUN cycles for a given multiplier value.
    function automatic int model_k(input int b);
`ifdef MULT_SEQ_SKIP_ZERO_EN
        int k;
        k = 1;
        for (int i = 0; i < N; i++) if ((b >> i) & 1) k = i + 1;
        return k;
`else
        return N;
`endif
    endfunction

    task automatic run_op(input int a, input int b, input int bp);
        int  k;
        int  lat;
        longint exp;
        exp = longint'(a) * longint'(b);
        k   = model_k(b);
        @(negedge clk);
        chk("in_ready_idle", bus.in_ready, 1);
        bus.in_valid        = 1'b1;
        bus.in_multiplicand = N'(a);
        bus.in_multiplier   = N'(b);
        bus.out_ready       = (bp == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 4 * N; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = c;
                break;
            end
            chk("busy_run", bus.busy, 1);
            chk("in_ready_run", bus.in_ready, 0);
            // Operand changes during RUN must have no effect.
            bus.in_multiplicand = N'($urandom);
            bus.in_multiplier   = N'($urandom);
        end
        if (lat == 0) begin
            chk("done_timeout", 0, 1);
            return;
        end
        chk("latency", lat, k + 1);
        chk("product", bus.out_product, exp);
        chk("cycles", bus.out_cycles, k);
        chk("busy_done", bus.busy, 1);
        if (bp > 0) begin
            bus.in_valid = 1'b1;
            repeat (bp) begin
                @(negedge clk);
                chk("bp_product", bus.out_product, exp);
                chk("bp_valid", bus.out_valid, 1);
                chk("bp_in_ready", bus.in_ready, 0);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("back_idle", bus.in_ready, 1);
        chk("valid_drop", bus.out_valid, 0);
        chk("busy_drop", bus.busy, 0);
    endtask

    initial begin
        bus.in_valid        = 1'b0;
        bus.in_multiplicand = '0;
        bus.in_multiplier   = '0;
        bus.out_ready       = 1'b0;
        #12;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_product", bus.out_product, 0);
        chk("rst_cycles", bus.out_cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(31, 31, 0);
        run_op(13, 0, 0);
        run_op(7, 3, 0);
        run_op(6, 16, 0);
        run_op(9, 11, 10);
        run_op(5, 5, 0);
        run_op(0, 31, 1);
        run_op(31, 1, 0);

        // Reset asserted in the middle of RUN aborts immediately.
        @(negedge clk);
        bus.in_valid        = 1'b1;
        bus.in_multiplicand = N'(25);
        bus.in_multiplier   = N'(19);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_product", bus.out_product, 0);
        chk("mid_rst_cycles", bus.out_cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(25, 19, 0);

        for (int i = 0; i < 40; i++) begin
            int a, b;
            a = $urandom_range(0, (1 << N) - 1);
            b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, (1 << N) - 1);
            run_op(a, b, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end
endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequential shift-and-add multiplier controller for unsigned n-bit operands. Accepts one operand pair over a valid/ready handshake, steps through the multiplier bits one per clock, forms each gated and shifted partial product, and accumulates it into a 2n-bit product. Returns the result over a second valid/ready handshake. It is the time-multiplexed alternative to the fully parallel partial-product array in the same multiplier datapath.

## Interface
- `n`, default 5: operand width in bits; legal range n ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  controller can accept an operand pair; high only in IDLE.
- `in_multiplicand`  in  n  unsigned multiplicand.
- `in_multiplier`  in  n  unsigned multiplier.
- `out_valid`  out  1  product valid; high only in DONE.
- `out_ready`  in  1  consumer accepts the product.
- `out_product`  out  2n  unsigned product.
- `out_cycles`  out  $clog2(n)+1  number of RUN cycles used for the current product.
- `busy`  out  1  high in RUN or DONE.

## Operation
- Internal state:
  - `mcand` register, 2n bits, zero-extended multiplicand.
  - `mplier` register, n bits.
  - `idx` counter, 0..n-1.
  - `acc` register, 2n bits.
  - `cycles` counter.
- States:
  - **IDLE**: in_ready=1. On in_valid&&in_ready, latch operands, clear acc, idx and cycles, then go to RUN.
  - **RUN**: each cycle, acc ← acc + (mplier[idx] ? mcand<<idx : 0); idx ← idx+1; cycles ← cycles+1.
    - Go to DONE after processing idx = n-1.
    - Go to DONE early when the skip condition holds (see Configuration).
  - **DONE**: out_valid=1. out_product=acc and out_cycles=cycles are held stable. On out_ready, go to IDLE.
- Arithmetic is unsigned modulo 2^(2n). Overflow cannot occur, since the maximum product is (2^n-1)^2.
- Operand inputs are ignored outside the IDLE acceptance cycle. Changing them during RUN has no effect.
- No input is accepted while busy. There is no overlap between consecutive operations.
- Reset, whether idle or mid-operation, aborts immediately:
  - state = IDLE; acc, idx, cycles, mcand, mplier = 0.
  - out_valid=0, busy=0, in_ready=1, out_product=0, out_cycles=0.

## Timing
- Acceptance occurs in cycle T.
- RUN occupies cycles T+1 .. T+k, where k = n without the skip feature, or 1 ≤ k ≤ n with it.
- out_valid rises at T+k+1 and stays high until the cycle in which out_ready=1. The state is IDLE the following cycle.
- in_ready is therefore high at T+k+2 at the earliest.
- Best-case throughput is one product per k+2 cycles.
- out_ready high in the same cycle out_valid rises counts as an immediate accept.
- out_ready while not in DONE is ignored.
- in_valid while not in IDLE is ignored; the producer must hold in_valid until it sees in_ready.
- All outputs are registered or decoded from registered state only. There is no combinational path from in_* or out_ready to any output.

## Configuration
- `MULT_SEQ_SKIP_ZERO_EN`:
  - **Defined**: RUN also exits to DONE after processing idx when (mplier >> (idx+1)) == 0. This skips trailing zero multiplier bits. A zero multiplier takes k=1, and multiplier value m>0 takes k = floor(log2 m)+1.
  - **Undefined**: k is always n. The skip comparator is not synthesised.
  - In both cases the product is identical and out_cycles reports k.

## Test plan
- n=5, 31×31, out_ready held high:
  - Product 961 (0x3C1), out_cycles=5.
  - out_valid at T+6, in_ready back high at T+7.
- n=5, 13×0:
  - Product 0.
  - With MULT_SEQ_SKIP_ZERO_EN: k=1, out_valid at T+2. Without it: k=5.
- n=5, 7×3 with the macro defined:
  - Product 21, out_cycles=2.
  - Then 6×16: product 96, out_cycles=5.
- Backpressure: 9×11, out_ready low for 10 cycles after out_valid.
  - out_product stays 99 and out_valid stays 1 throughout.
  - in_ready stays 0 even with in_valid held high.
  - Returns to IDLE one cycle after out_ready.
- Reset mid-RUN: assert rst_n=0 at T+3 of 25×19.
  - All outputs go to reset values asynchronously.
  - After release, 25×19 is accepted and yields 475.
- Operand change during RUN: accept 5×5, then drive in_multiplicand=31 and in_multiplier=31 during RUN.
  - Result remains 25.
